// File: rtl/mem_ctl_pkg.sv
// Shared constants and types for the memory arbiter/sequencer slice.
// State encodings are plain constants so older tools and dumps read them as raw values.
package mem_ctl_pkg;

   localparam int CNT_W  = 3;
   localparam int ADDR_W = 15;
   localparam int DATA_W = 32;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_RD_WAIT  = 3'd1;
   localparam logic [2:0] S_WR_SETUP = 3'd2;
   localparam logic [2:0] S_WR_PULSE = 3'd3;
   localparam logic [2:0] S_WR_HOLD  = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   // Everything about the granted access that must stay frozen until DONE.
   typedef struct packed {
      logic              id;
      logic              wr;
      logic [3:0]        be;
      logic [DATA_W-1:0] wdata;
   } xfer_t;

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the preferred requester
// and flips to the other one whenever a grant is taken.
module mem_rr_arb2 (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic en,
   output logic grant_valid,
   output logic grant_id
);

   logic ptr_q;
   logic ptr_d;

   always_comb begin
      grant_valid = req0 | req1;
      grant_id    = (req0 && req1) ? ptr_q : req1;
      ptr_d       = ptr_q;
      if (en && grant_valid) begin
         ptr_d = ~grant_id;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/mem_arbiter_ctl.sv
// Memory sequencer: round-robin grant, read latency wait, and write setup/pulse/hold timing.
// Defining MEMCTL_BURST_EN adds 4-word line-wrapping burst reads for requester 0.
module mem_arbiter_ctl
   import mem_ctl_pkg::*;
#(
   parameter int RD_LAT   = 2,
   parameter int WR_SETUP = 1,
   parameter int WR_PULSE = 2,
   parameter int WR_HOLD  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef MEMCTL_BURST_EN
   input  logic              burst0,
   output logic              rvalid0,
`endif
   input  logic              req0,
   input  logic              req1,
   input  logic              wr0,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [3:0]        be0,
   input  logic [3:0]        be1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_we,
   output logic              mem_oe,
   output logic              mem_wr_n,
   inout  wire  [DATA_W-1:0] mem_data
);

   localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] SU_LOAD  = CNT_W'(WR_SETUP - 1);
   localparam logic [CNT_W-1:0] PW_LOAD  = CNT_W'(WR_PULSE - 1);
   localparam logic [CNT_W-1:0] HLD_LOAD = CNT_W'(WR_HOLD - 1);

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   xfer_t             xfer_q, xfer_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [3:0]        mem_we_q, mem_we_d;
   logic              mem_oe_q, mem_oe_d;
   logic              mem_wr_n_q, mem_wr_n_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              grant_valid;
   logic              grant_id;
   logic              unused_addr_lsbs;

`ifdef MEMCTL_BURST_EN
   logic              burst_q, burst_d;
   logic [1:0]        beat_q, beat_d;
   logic              rvalid0_q, rvalid0_d;
`endif

   mem_rr_arb2 u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0        (req0),
      .req1        (req1),
      .en          (state_q == S_IDLE),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   // Each state reloads the down-counter on entry and leaves when it reaches zero.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      xfer_d     = xfer_q;
      mem_addr_d = mem_addr_q;
      mem_we_d   = mem_we_q;
      mem_oe_d   = mem_oe_q;
      mem_wr_n_d = mem_wr_n_q;
      rdata_d    = rdata_q;
`ifdef MEMCTL_BURST_EN
      burst_d    = burst_q;
      beat_d     = beat_q;
      rvalid0_d  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (grant_valid) begin
               xfer_d.id    = grant_id;
               xfer_d.wr    = grant_id ? wr1 : wr0;
               xfer_d.be    = grant_id ? be1 : be0;
               xfer_d.wdata = grant_id ? wdata1 : wdata0;
               mem_addr_d   = grant_id ? {addr1[ADDR_W-1:2], 2'b00} : {addr0[ADDR_W-1:2], 2'b00};
`ifdef MEMCTL_BURST_EN
               burst_d      = !grant_id && !wr0 && burst0;
               beat_d       = 2'd0;
`endif
               if (xfer_d.wr) begin
                  state_d  = S_WR_SETUP;
                  cnt_d    = SU_LOAD;
                  mem_oe_d = 1'b1;
                  mem_we_d = xfer_d.be;
               end else begin
                  state_d  = S_RD_WAIT;
                  cnt_d    = RD_LOAD;
               end
            end
         end
         S_RD_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               rdata_d = mem_data;
`ifdef MEMCTL_BURST_EN
               rvalid0_d = burst_q;
               // Burst steps the word index inside the 16-byte line, wrapping 3 -> 0.
               if (burst_q && beat_q != 2'd3) begin
                  beat_d     = beat_q + 2'd1;
                  mem_addr_d = {mem_addr_q[ADDR_W-1:4], mem_addr_q[3:2] + 2'd1, 2'b00};
                  cnt_d      = RD_LOAD;
               end else begin
                  state_d = S_DONE;
               end
`else
               state_d = S_DONE;
`endif
            end
         end
         S_WR_SETUP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d    = S_WR_PULSE;
               cnt_d      = PW_LOAD;
               mem_wr_n_d = 1'b0;
            end
         end
         S_WR_PULSE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d    = S_WR_HOLD;
               cnt_d      = HLD_LOAD;
               mem_wr_n_d = 1'b1;
            end
         end
         S_WR_HOLD: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d  = S_DONE;
               mem_oe_d = 1'b0;
               mem_we_d = 4'b0000;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d    = S_IDLE;
            mem_oe_d   = 1'b0;
            mem_we_d   = 4'b0000;
            mem_wr_n_d = 1'b1;
         end
      endcase
   end

   // Reset forces the write strobe high on the same edge, cutting off any pulse in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         xfer_q     <= '0;
         mem_addr_q <= '0;
         mem_we_q   <= 4'b0000;
         mem_oe_q   <= 1'b0;
         mem_wr_n_q <= 1'b1;
         rdata_q    <= '0;
`ifdef MEMCTL_BURST_EN
         burst_q    <= 1'b0;
         beat_q     <= 2'd0;
         rvalid0_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         xfer_q     <= xfer_d;
         mem_addr_q <= mem_addr_d;
         mem_we_q   <= mem_we_d;
         mem_oe_q   <= mem_oe_d;
         mem_wr_n_q <= mem_wr_n_d;
         rdata_q    <= rdata_d;
`ifdef MEMCTL_BURST_EN
         burst_q    <= burst_d;
         beat_q     <= beat_d;
         rvalid0_q  <= rvalid0_d;
`endif
      end
   end

`ifdef MEMCTL_BURST_EN
   assign rvalid0 = rvalid0_q;
`endif

   assign unused_addr_lsbs = ^{addr0[1:0], addr1[1:0]};

   assign done0    = (state_q == S_DONE) && !xfer_q.id;
   assign done1    = (state_q == S_DONE) && xfer_q.id;
   assign busy     = (state_q != S_IDLE);
   assign rdata    = rdata_q;
   assign mem_addr = mem_addr_q;
   assign mem_we   = mem_we_q;
   assign mem_oe   = mem_oe_q;
   assign mem_wr_n = mem_wr_n_q;
   assign mem_data = mem_oe_q ? xfer_q.wdata : 'z;

endmodule

// File: tb/tb_mem_arbiter_ctl.sv
// Directed bench for mem_arbiter_ctl with a byte-enabled memory model on the shared bus.
// Burst scenario is compiled in only when MEMCTL_BURST_EN is defined.
module tb_mem_arbiter_ctl;

   logic        clk;
   logic        rst_n;
   logic        req0, req1, wr0, wr1;
   logic [14:0] addr0, addr1;
   logic [3:0]  be0, be1;
   logic [31:0] wdata0, wdata1;
   logic        done0, done1, busy;
   logic [31:0] rdata;
   logic [14:0] mem_addr;
   logic [3:0]  mem_we;
   logic        mem_oe, mem_wr_n;
   wire  [31:0] mem_data;
`ifdef MEMCTL_BURST_EN
   logic        burst0;
   logic        rvalid0;
`endif

   logic [31:0] mem [0:8191];

   int total;
   int bad;
   int viol;
   logic mon_en;
   logic prev_oe, prev_wr_n;
   logic [14:0] prev_addr;
   logic [3:0]  prev_we;
   logic [31:0] prev_data;

   int got, lat, oe_cyc, low_cyc, we_bad, cnt, last, id, nd;

   mem_arbiter_ctl dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef MEMCTL_BURST_EN
      .burst0   (burst0),
      .rvalid0  (rvalid0),
`endif
      .req0     (req0),
      .req1     (req1),
      .wr0      (wr0),
      .wr1      (wr1),
      .addr0    (addr0),
      .addr1    (addr1),
      .be0      (be0),
      .be1      (be1),
      .wdata0   (wdata0),
      .wdata1   (wdata1),
      .done0    (done0),
      .done1    (done1),
      .rdata    (rdata),
      .busy     (busy),
      .mem_addr (mem_addr),
      .mem_we   (mem_we),
      .mem_oe   (mem_oe),
      .mem_wr_n (mem_wr_n),
      .mem_data (mem_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory drives the bus only when the controller is not driving it.
   assign mem_data = mem_oe ? 32'bz : mem[mem_addr[14:2]];

   always @(posedge clk) begin
      if (!mem_wr_n && mem_oe) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_we[i]) mem[mem_addr[14:2]][8*i +: 8] <= mem_data[8*i +: 8];
         end
      end
   end

   // Bus protocol monitor: strobe only inside OE, OE steady under strobe, bus steady while OE.
   always @(negedge clk) begin
      if (mon_en) begin
         if (!mem_wr_n && !mem_oe) viol++;
         if (!prev_wr_n && !mem_wr_n && (mem_oe !== prev_oe)) viol++;
         if (prev_oe && mem_oe && ((mem_addr !== prev_addr) || (mem_we !== prev_we) || (mem_data !== prev_data))) viol++;
      end
      prev_oe   = mem_oe;
      prev_wr_n = mem_wr_n;
      prev_addr = mem_addr;
      prev_we   = mem_we;
      prev_data = mem_data;
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   task automatic test_reset();
      rst_n = 1'b0;
      req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
      addr0 = '0; addr1 = '0; be0 = '0; be1 = '0; wdata0 = '0; wdata1 = '0;
`ifdef MEMCTL_BURST_EN
      burst0 = 1'b0;
`endif
      @(negedge clk);
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
      total++; if ({done0, done1} !== 2'b00) begin bad++; $display("[TB] FAIL reset_done got=%b want=00", {done0, done1}); end
      total++; if (rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata got=%h want=0", rdata); end
      total++; if (mem_oe !== 1'b0) begin bad++; $display("[TB] FAIL reset_oe got=%b want=0", mem_oe); end
      total++; if (mem_wr_n !== 1'b1) begin bad++; $display("[TB] FAIL reset_wr_n got=%b want=1", mem_wr_n); end
      total++; if (mem_we !== 4'h0) begin bad++; $display("[TB] FAIL reset_we got=%h want=0", mem_we); end
      total++; if (mem_addr !== 15'h0) begin bad++; $display("[TB] FAIL reset_addr got=%h want=0", mem_addr); end
      rst_n = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic test_read();
      mem[15'h0104 >> 2] = 32'hDEADBEEF;
      req1 = 1; wr1 = 0; addr1 = 15'h0104;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k <= 3) begin
            total++; if (mem_oe !== 1'b0) begin bad++; $display("[TB] FAIL read_oe k=%0d got=%b want=0", k, mem_oe); end
            total++; if (mem_addr !== 15'h0104) begin bad++; $display("[TB] FAIL read_addr k=%0d got=%h want=0104", k, mem_addr); end
            total++; if (done1 !== (k == 3)) begin bad++; $display("[TB] FAIL read_done1 k=%0d got=%b want=%b", k, done1, (k == 3)); end
         end
         if (k == 3) begin
            total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL read_rdata got=%h want=deadbeef", rdata); end
            req1 = 0;
         end
         if (k == 4) begin
            total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL read_idle_busy got=%b want=0", busy); end
         end
      end
   endtask

   task automatic test_write();
      mem[15'h7FFC >> 2] = 32'hAABBCCDD;
      req0 = 1; wr0 = 1; addr0 = 15'h7FFF; be0 = 4'b0101; wdata0 = 32'h11223344;
      oe_cyc = 0; low_cyc = 0; got = 0; lat = 0;
      for (int k = 1; k <= 12 && got == 0; k++) begin
         @(negedge clk);
         if (mem_oe) oe_cyc++;
         if (!mem_wr_n) low_cyc++;
         if (k == 2) begin
            total++; if (mem_addr !== 15'h7FFC) begin bad++; $display("[TB] FAIL write_addr got=%h want=7ffc", mem_addr); end
            total++; if (mem_we !== 4'b0101) begin bad++; $display("[TB] FAIL write_we got=%b want=0101", mem_we); end
            total++; if (mem_data !== 32'h11223344) begin bad++; $display("[TB] FAIL write_bus got=%h want=11223344", mem_data); end
            total++; if (mem_wr_n !== 1'b0) begin bad++; $display("[TB] FAIL write_pulse_start got=%b want=0", mem_wr_n); end
         end
         if (done0) begin got = 1; lat = k; req0 = 0; wr0 = 0; end
      end
      total++; if (lat !== 5) begin bad++; $display("[TB] FAIL write_latency got=%0d want=5", lat); end
      total++; if (oe_cyc !== 4) begin bad++; $display("[TB] FAIL write_oe_window got=%0d want=4", oe_cyc); end
      total++; if (low_cyc !== 2) begin bad++; $display("[TB] FAIL write_pulse_width got=%0d want=2", low_cyc); end
      total++; if (mem_we !== 4'b0000) begin bad++; $display("[TB] FAIL write_done_we got=%b want=0000", mem_we); end
      @(negedge clk);
      req0 = 1; addr0 = 15'h7FFC;
      got = 0;
      for (int k = 1; k <= 10 && got == 0; k++) begin
         @(negedge clk);
         if (done0) begin got = 1; req0 = 0; end
      end
      total++; if (got !== 1) begin bad++; $display("[TB] FAIL readback_timeout got=%0d want=1", got); end
      total++; if (rdata !== 32'hAA22CC44) begin bad++; $display("[TB] FAIL readback_data got=%h want=aa22cc44", rdata); end
   endtask

   task automatic test_back_to_back();
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      mem[15'h0200 >> 2] = 32'hA0A00000;
      mem[15'h0300 >> 2] = 32'hB1B11111;
      req0 = 1; req1 = 1; wr0 = 0; wr1 = 0; addr0 = 15'h0200; addr1 = 15'h0300;
      cnt = 0; last = 0;
      for (int k = 1; k <= 100 && cnt < 8; k++) begin
         @(negedge clk);
         if (done0 || done1) begin
            id = done1 ? 1 : 0;
            total++; if (done0 && done1) begin bad++; $display("[TB] FAIL arb_both_done got=11 want=one-hot"); end
            total++; if (id !== (cnt % 2)) begin bad++; $display("[TB] FAIL arb_order n=%0d got=%0d want=%0d", cnt, id, cnt % 2); end
            total++; if (rdata !== (id ? 32'hB1B11111 : 32'hA0A00000)) begin bad++; $display("[TB] FAIL arb_rdata n=%0d got=%h", cnt, rdata); end
            if (cnt == 0) begin
               total++; if (k !== 3) begin bad++; $display("[TB] FAIL arb_first_latency got=%0d want=3", k); end
            end else begin
               total++; if ((k - last) !== 4) begin bad++; $display("[TB] FAIL arb_gap n=%0d got=%0d want=4", cnt, k - last); end
            end
            last = k;
            cnt++;
            if (cnt == 8) begin req0 = 0; req1 = 0; end
         end
      end
      total++; if (cnt !== 8) begin bad++; $display("[TB] FAIL arb_count got=%0d want=8", cnt); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_write();
      req0 = 1; wr0 = 1; addr0 = 15'h0040; be0 = 4'b1111; wdata0 = 32'hCAFEF00D;
      @(negedge clk);
      @(negedge clk);
      total++; if (mem_wr_n !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_in_pulse got=%b want=0", mem_wr_n); end
      rst_n = 0; req0 = 0; wr0 = 0;
      @(negedge clk);
      total++; if (mem_wr_n !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_wr_n got=%b want=1", mem_wr_n); end
      total++; if (mem_oe !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_oe got=%b want=0", mem_oe); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy got=%b want=0", busy); end
      rst_n = 1;
      nd = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done0 || done1) nd++;
      end
      total++; if (nd !== 0) begin bad++; $display("[TB] FAIL rstmid_no_done got=%0d want=0", nd); end
      req1 = 1; wr1 = 0; addr1 = 15'h0104;
      got = 0; lat = 0;
      for (int k = 1; k <= 10 && got == 0; k++) begin
         @(negedge clk);
         if (done1) begin got = 1; lat = k; req1 = 0; end
      end
      total++; if (lat !== 3) begin bad++; $display("[TB] FAIL rstmid_read_latency got=%0d want=3", lat); end
      total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL rstmid_read_data got=%h want=deadbeef", rdata); end
      @(negedge clk);
   endtask

   task automatic test_be_zero();
      mem[0] = 32'h12345678;
      req0 = 1; wr0 = 1; addr0 = 15'h0000; be0 = 4'b0000; wdata0 = 32'hFFFFFFFF;
      oe_cyc = 0; low_cyc = 0; we_bad = 0; got = 0; lat = 0;
      for (int k = 1; k <= 12 && got == 0; k++) begin
         @(negedge clk);
         if (mem_oe) oe_cyc++;
         if (!mem_wr_n) low_cyc++;
         if (mem_we !== 4'b0000) we_bad++;
         if (done0) begin got = 1; lat = k; req0 = 0; wr0 = 0; end
      end
      total++; if (lat !== 5) begin bad++; $display("[TB] FAIL be0_latency got=%0d want=5", lat); end
      total++; if (oe_cyc !== 4) begin bad++; $display("[TB] FAIL be0_oe_window got=%0d want=4", oe_cyc); end
      total++; if (low_cyc !== 2) begin bad++; $display("[TB] FAIL be0_pulse_width got=%0d want=2", low_cyc); end
      total++; if (we_bad !== 0) begin bad++; $display("[TB] FAIL be0_we got=%0d nonzero cycles want=0", we_bad); end
      @(negedge clk);
      total++; if (mem[0] !== 32'h12345678) begin bad++; $display("[TB] FAIL be0_mem got=%h want=12345678", mem[0]); end
   endtask

`ifdef MEMCTL_BURST_EN
   task automatic test_burst();
      logic [31:0] exp_w [0:3];
      mem[4] = 32'h40404040; mem[5] = 32'h51515151; mem[6] = 32'h62626262; mem[7] = 32'h73737373;
      exp_w[0] = 32'h62626262; exp_w[1] = 32'h73737373; exp_w[2] = 32'h40404040; exp_w[3] = 32'h51515151;
      req0 = 1; wr0 = 0; burst0 = 1; addr0 = 15'h0018;
      nd = 0; got = 0;
      for (int k = 1; k <= 40 && got == 0; k++) begin
         @(negedge clk);
         if (rvalid0) begin
            if (nd < 4) begin
               total++; if (rdata !== exp_w[nd]) begin bad++; $display("[TB] FAIL burst_word n=%0d got=%h want=%h", nd, rdata, exp_w[nd]); end
            end
            nd++;
         end
         if (done0) begin
            got = 1; req0 = 0; burst0 = 0;
            total++; if (rvalid0 !== 1'b1) begin bad++; $display("[TB] FAIL burst_done_align got=%b want=1", rvalid0); end
         end
      end
      total++; if (nd !== 4) begin bad++; $display("[TB] FAIL burst_rvalid_count got=%0d want=4", nd); end
      total++; if (got !== 1) begin bad++; $display("[TB] FAIL burst_timeout got=%0d want=1", got); end
      @(negedge clk);
   endtask
`endif

   task automatic test_protocol();
      total++; if (viol !== 0) begin bad++; $display("[TB] FAIL bus_protocol got=%0d violations want=0", viol); end
   endtask

   initial begin
      total = 0; bad = 0; viol = 0; mon_en = 1'b0;
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_reset_mid_write();
      test_be_zero();
`ifdef MEMCTL_BURST_EN
      test_burst();
`endif
      test_protocol();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
